// File: rtl/rx_controller.sv
// UART receive controller: decodes raw frames and stores {data, fe, pe} entries.
// Define ECAP5_WBUART_RX_FIFO_EN for 4-entry storage; otherwise a single holding register.
module rx_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] frame_i,
  input  logic        frame_valid_i,
  input  logic        cfg_ds_i,
  input  logic        cfg_pe_i,
  input  logic        cfg_ps_i,
  input  logic        rx_read_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_fe_o,
  output logic        rx_pe_o,
  output logic        rx_rdy_o,
  output logic        rx_oe_o,
  output logic [2:0]  rx_count_o
);

`ifdef ECAP5_WBUART_RX_FIFO_EN
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
`else
  localparam int unsigned DEPTH = 1;
  localparam int unsigned PTR_W = 1;
`endif
  localparam logic [2:0]       DEPTH_C = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Decode stage
  // ---------------------------------------------------------------------------
  logic        dec_valid_q;
  logic [10:0] dec_frame_q;
  logic        dec_ds_q;
  logic        dec_pe_en_q;
  logic        dec_ps_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_valid_q <= 1'b0;
    end else begin
      dec_valid_q <= frame_valid_i;
    end
  end

  // NOTE: payload and storage registers carry no reset; a valid flag or the
  // entry count qualifies them, so their power-up contents are never observed.
  always_ff @(posedge clk_i) begin
    if (frame_valid_i) begin
      dec_frame_q <= frame_i;
      dec_ds_q    <= cfg_ds_i;
      dec_pe_en_q <= cfg_pe_i;
      dec_ps_q    <= cfg_ps_i;
    end
  end

  logic [1:0] start_idx;
  logic [9:0] shifted;
  logic [7:0] dec_data;
  logic       dec_par;
  logic       dec_fe;
  logic       dec_pe;

  // NOTE: every always_comb output gets a value on every path (here by
  // straight-line assignment), so no latch can be inferred.
  always_comb begin
    // Frame is right-aligned to bit 10; shorter frames start higher up.
    start_idx = 2'd2 - {1'b0, dec_ds_q} - {1'b0, dec_pe_en_q};
    shifted   = 10'(dec_frame_q >> start_idx);
    dec_data  = dec_ds_q ? shifted[8:1] : {1'b0, shifted[7:1]};
    dec_par   = dec_ds_q ? shifted[9] : shifted[8];
    dec_fe    = shifted[0] | ~dec_frame_q[10];
    dec_pe    = dec_pe_en_q & ((^dec_data ^ dec_par) != dec_ps_q);
  end

  // ---------------------------------------------------------------------------
  // Store stage
  // ---------------------------------------------------------------------------
  logic [9:0]       mem [2**PTR_W];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [2:0]       count_q;
  logic             oe_q;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic overrun;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty   = (count_q == 3'd0);
    full    = (count_q == DEPTH_C);
    pop     = rx_read_i & ~empty;
    // A pop in the same cycle frees the slot, so a full store still lands.
    push    = dec_valid_q & (~full | pop);
    overrun = dec_valid_q & full & ~pop;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
      oe_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      // Set wins over the clear from an accepted read.
      if (overrun)  oe_q <= 1'b1;
      else if (pop) oe_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem[wr_ptr_q] <= {dec_data, dec_fe, dec_pe};
    end
  end

  logic [9:0] head;

  always_comb begin
    head = empty ? 10'd0 : mem[rd_ptr_q];
  end

  assign rx_data_o  = head[9:2];
  assign rx_fe_o    = head[1];
  assign rx_pe_o    = head[0];
  assign rx_rdy_o   = ~empty;
  assign rx_oe_o    = oe_q;
  assign rx_count_o = count_q;

endmodule
